// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array feeder blocks.
package sa_pkg;

  // Lane width: one IEEE-754 double per lane.
  localparam int SA_W = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } sa_skew_state_t;

  // Low bit index of lane k in a flat bus of w-bit lanes.
  function automatic int sa_lane_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/sa_delay_line.sv
// Fixed-depth delay line carrying data plus valid/last side bits.
// The last stage is the output register; the line shifts every cycle.
module sa_delay_line #(
  parameter int DEPTH = 1,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         in_vld,
  input  logic         in_last,
  output logic [W-1:0] out_data,
  output logic         out_vld,
  output logic         out_last,
  output logic         any_vld
);

  logic [DEPTH-1:0][W-1:0] data_pipe;
  logic [DEPTH-1:0]        vld_pipe;
  logic [DEPTH-1:0]        last_pipe;

  // Unconditional shift; reset wipes every stage so a partial matrix is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_pipe <= '0;
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      data_pipe[0] <= in_data;
      vld_pipe[0]  <= in_vld;
      last_pipe[0] <= in_last;
      for (int i = 1; i < DEPTH; i++) begin
        data_pipe[i] <= data_pipe[i-1];
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
    end
  end

  assign out_data = data_pipe[DEPTH-1];
  assign out_vld  = vld_pipe[DEPTH-1];
  assign out_last = last_pipe[DEPTH-1];
  assign any_vld  = |vld_pipe;

endmodule

// File: rtl/sa_input_skew.sv
// Row-to-diagonal skew feeder for the SA_MxN systolic array.
// Lane k is delayed k cycles relative to lane 0; after the last row the
// block injects M-1 zero flush cycles on its own.
// Optional feature: define SA_SKEW_ROWCNT_EN to add the row_count output.
module sa_input_skew
  import sa_pkg::*;
#(
  parameter int M = 3,
  parameter int W = SA_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W*M-1:0] in_row,
  input  logic           in_last,
  output logic [W*M-1:0] out_left,
  output logic           out_valid,
  output logic           out_last,
  output logic           busy
`ifdef SA_SKEW_ROWCNT_EN
  ,output logic [15:0]   row_count
`endif
);

  // M=1 needs no flush, but keep the counter at least one bit wide.
  localparam int CW = (M > 1) ? $clog2(M) : 1;

  sa_skew_state_t       state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 accept;
  logic [M-1:0][W-1:0]  lane_data;
  logic [M-1:0]         lane_vld;
  logic [M-1:0]         lane_last;
  logic [M-1:0]         lane_any;

  assign in_ready = (state_q != FLUSH) && !reset;
  assign accept   = in_valid && in_ready;

  // One delay line per lane, depth k+1; bubbles inject zero.
  for (genvar k = 0; k < M; k++) begin : g_lane
    sa_delay_line #(
      .DEPTH (k + 1),
      .W     (W)
    ) u_dl (
      .clk      (clk),
      .reset    (reset),
      .in_data  (accept ? in_row[sa_lane_lo(k, W) +: W] : '0),
      .in_vld   (accept),
      .in_last  (accept && in_last),
      .out_data (lane_data[k]),
      .out_vld  (lane_vld[k]),
      .out_last (lane_last[k]),
      .any_vld  (lane_any[k])
    );
  end

  assign out_left  = lane_data;
  assign out_valid = |lane_vld;
  assign out_last  = lane_last[M-1];
  assign busy      = (state_q != IDLE) || (|lane_any);

  // State and flush-counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: FLUSH holds off new rows for M-1 cycles after the last row.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, STREAM: begin
        if (accept) begin
          if (in_last) begin
            if (M > 1) begin
              state_d = FLUSH;
              cnt_d   = CW'(M - 2);
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = STREAM;
          end
        end
      end
      FLUSH: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SA_SKEW_ROWCNT_EN
  // Rows accepted in the current matrix; an accept from IDLE starts a new one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     row_count <= '0;
    else if (accept) begin
      if (state_q == IDLE)         row_count <= 16'd1;
      else if (row_count != 16'hFFFF) row_count <= row_count + 16'd1;
    end
  end
`endif

endmodule
